// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: instruction fields,
// ALU operation codes, FSM states, instruction classes and the control bundle.
package ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SUBI = 6'b101010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_BGT  = 6'b000111;
   localparam logic [5:0] OP_BLT  = 6'b000001;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_JR   = 6'b001111;
   localparam logic [5:0] OP_OUT  = 6'b101110;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_COMP = 6'b111111;

   // Several codes are shared: BNE reuses COMP, BLT reuses SLT.
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_CMP  = 4'b0011;
   localparam logic [3:0] ALU_BGT  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_MULT = 4'b1000;
   localparam logic [3:0] ALU_DIV  = 4'b1001;
   localparam logic [3:0] ALU_BEQ  = 4'b1010;
   localparam logic [3:0] ALU_BAD  = 4'b1111;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MULDIV_WAIT,
      ST_MEM,
      ST_WB,
      ST_OUT_WAIT,
      ST_HALTED
   } state_e;

   typedef enum logic [2:0] {
      CL_NOP,
      CL_ALU,
      CL_MULDIV,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH,
      CL_OUT,
      CL_HALT
   } class_e;

   typedef struct packed {
      logic       reg_dst;
      logic       jump;
      logic       branch;
      logic       mem_to_reg;
      logic       alu_src;
      logic       jal;
      logic       jr;
      logic [3:0] alu_ctr;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/control_decoder.sv
// Combinational instruction decoder: {opcode, funct} to control bundle,
// instruction class and illegal flag.
module control_decoder
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int FUNCT_W  = 6
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   output ctrl_t               ctrl_o,
   output class_e              class_o,
   output logic                illegal_o
);

   always_comb begin
      // NOTE: every output is given a default first so no path through the case infers a latch.
      ctrl_o    = CTRL_NONE;
      class_o   = CL_NOP;
      illegal_o = 1'b0;
      case (opcode_i)
         OP_R: begin
            ctrl_o.reg_dst = 1'b1;
            class_o        = CL_ALU;
            case (funct_i)
               FN_MULT: begin
                  ctrl_o.alu_ctr = ALU_MULT;
                  class_o        = CL_MULDIV;
               end
               FN_DIV: begin
                  ctrl_o.alu_ctr = ALU_DIV;
                  class_o        = CL_MULDIV;
               end
               FN_ADD:  ctrl_o.alu_ctr = ALU_ADD;
               FN_SUB:  ctrl_o.alu_ctr = ALU_SUB;
               FN_AND:  ctrl_o.alu_ctr = ALU_AND;
               FN_OR:   ctrl_o.alu_ctr = ALU_OR;
               FN_SLT:  ctrl_o.alu_ctr = ALU_SLT;
               FN_COMP: ctrl_o.alu_ctr = ALU_CMP;
               default: begin
                  // Unknown funct retires as a NOP with no datapath selects.
                  ctrl_o         = CTRL_NONE;
                  ctrl_o.alu_ctr = ALU_BAD;
                  class_o        = CL_NOP;
                  illegal_o      = 1'b1;
               end
            endcase
         end
         OP_ADDI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_ctr = ALU_ADD;
            class_o        = CL_ALU;
         end
         OP_SUBI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_ctr = ALU_SUB;
            class_o        = CL_ALU;
         end
         OP_LW: begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.alu_ctr    = ALU_ADD;
            class_o           = CL_LOAD;
         end
         OP_SW: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_ctr = ALU_ADD;
            class_o        = CL_STORE;
         end
         OP_BEQ: begin
            ctrl_o.branch  = 1'b1;
            ctrl_o.alu_ctr = ALU_BEQ;
            class_o        = CL_BRANCH;
         end
         OP_BNE: begin
            ctrl_o.branch  = 1'b1;
            ctrl_o.alu_ctr = ALU_CMP;
            class_o        = CL_BRANCH;
         end
         OP_BGT: begin
            ctrl_o.branch  = 1'b1;
            ctrl_o.alu_ctr = ALU_BGT;
            class_o        = CL_BRANCH;
         end
         OP_BLT: begin
            ctrl_o.branch  = 1'b1;
            ctrl_o.alu_ctr = ALU_SLT;
            class_o        = CL_BRANCH;
         end
         OP_J: begin
            ctrl_o.jump = 1'b1;
            class_o     = CL_BRANCH;
         end
         OP_JAL: begin
            ctrl_o.jump = 1'b1;
            ctrl_o.jal  = 1'b1;
            class_o     = CL_ALU;
         end
         OP_JR: begin
            ctrl_o.jr = 1'b1;
            class_o   = CL_BRANCH;
         end
         OP_OUT:  class_o = CL_OUT;
         OP_HALT: class_o = CL_HALT;
         default: begin
            ctrl_o.alu_ctr = ALU_BAD;
            illegal_o      = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with handshake
// waits, stretched MULT/DIV, OUT handshake, sticky HALT and retire pulse.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int INSTR_W    = 32,
   parameter int OPCODE_W   = 6,
   parameter int FUNCT_W    = 6,
   parameter int ALU_CTR_W  = 4,
   parameter int MULDIV_LAT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [INSTR_W-1:0]   instr,
   input  logic                 imem_ready,
   input  logic                 dmem_ready,
   input  logic                 out_ack,
   output logic                 ir_load,
   output logic                 pc_en,
   output logic                 RegDst,
   output logic                 jump,
   output logic                 Branch,
   output logic                 MemtoReg,
   output logic                 ALUSrc,
   output logic                 Jal,
   output logic                 JR,
   output logic [ALU_CTR_W-1:0] ALU_ctr,
   output logic                 reg_write,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 alu_start,
   output logic                 out_valid,
   output logic                 halted,
   output logic                 illegal
);

   localparam int CNT_W = $clog2(MULDIV_LAT) + 1;

   state_e              state_q, state_d;
   class_e              cls_q, cls_d, dec_cls;
   ctrl_t               ctrl_q, ctrl_d, dec_ctrl, sel;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic [FUNCT_W-1:0]  funct_q, funct_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dec_illegal;
   logic                unused_instr_bits;

   // Only opcode and funct steer control; the operand fields go to the datapath IR.
   assign unused_instr_bits = ^instr[INSTR_W-OPCODE_W-1:FUNCT_W];

   control_decoder #(
      .OPCODE_W (OPCODE_W),
      .FUNCT_W  (FUNCT_W)
   ) u_decoder (
      .opcode_i  (opcode_q),
      .funct_i   (funct_q),
      .ctrl_o    (dec_ctrl),
      .class_o   (dec_cls),
      .illegal_o (dec_illegal)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q  <= ST_FETCH;
         cls_q    <= CL_NOP;
         ctrl_q   <= CTRL_NONE;
         opcode_q <= '0;
         funct_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cls_q    <= cls_d;
         ctrl_q   <= ctrl_d;
         opcode_q <= opcode_d;
         funct_q  <= funct_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      ctrl_d    = ctrl_q;
      opcode_d  = opcode_q;
      funct_d   = funct_q;
      cnt_d     = cnt_q;
      ir_load   = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      alu_start = 1'b0;
      out_valid = 1'b0;
      illegal   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (imem_ready) begin
               ir_load  = 1'b1;
               opcode_d = instr[INSTR_W-1 -: OPCODE_W];
               funct_d  = instr[FUNCT_W-1:0];
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ctrl_d  = dec_ctrl;
            cls_d   = dec_cls;
            illegal = dec_illegal;
            case (dec_cls)
               CL_HALT: state_d = ST_HALTED;
               CL_OUT:  state_d = ST_OUT_WAIT;
               default: state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (cls_q)
               CL_MULDIV: begin
                  alu_start = 1'b1;
                  if (MULDIV_LAT > 1) begin
                     cnt_d   = CNT_W'(MULDIV_LAT - 1);
                     state_d = ST_MULDIV_WAIT;
                  end else begin
                     state_d = ST_WB;
                  end
               end
               CL_LOAD, CL_STORE: state_d = ST_MEM;
               CL_ALU:            state_d = ST_WB;
               default: begin
                  // Branches, jumps and NOPs retire straight out of EXEC.
                  pc_en   = 1'b1;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_MULDIV_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = ST_WB;
         end
         ST_MEM: begin
            mem_read  = (cls_q == CL_LOAD);
            mem_write = (cls_q == CL_STORE);
            if (dmem_ready) begin
               if (cls_q == CL_STORE) begin
                  pc_en   = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_write = 1'b1;
            pc_en     = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_OUT_WAIT: begin
            out_valid = 1'b1;
            if (out_ack) begin
               pc_en   = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_FETCH;
      endcase
      // Reset wins over any handshake: the in-flight strobe never reaches the datapath.
      if (reset) begin
         ir_load   = 1'b0;
         pc_en     = 1'b0;
         reg_write = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         alu_start = 1'b0;
         out_valid = 1'b0;
         illegal   = 1'b0;
      end
   end

   // Decoder drives the selects during DECODE so they are valid one cycle early.
   assign sel      = (state_q == ST_DECODE) ? dec_ctrl : ctrl_q;
   assign RegDst   = sel.reg_dst;
   assign jump     = sel.jump;
   assign Branch   = sel.branch;
   assign MemtoReg = sel.mem_to_reg;
   assign ALUSrc   = sel.alu_src;
   assign Jal      = sel.jal;
   assign JR       = sel.jr;
   assign ALU_ctr  = ALU_CTR_W'(sel.alu_ctr);
   assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: table of instructions scored through an expectation
// queue, plus hand-written HALT, reset-in-MEM and MULT latency sequences.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        imem_ready, dmem_ready, out_ack;

   logic       ir_load, pc_en, RegDst, jump, Branch, MemtoReg, ALUSrc, Jal, JR;
   logic [3:0] ALU_ctr;
   logic       reg_write, mem_read, mem_write, alu_start, out_valid, halted, illegal;

   logic       ir_load1, pc_en1, RegDst1, jump1, Branch1, MemtoReg1, ALUSrc1, Jal1, JR1;
   logic [3:0] ALU_ctr1;
   logic       reg_write1, mem_read1, mem_write1, alu_start1, out_valid1, halted1, illegal1;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MULDIV_LAT(4)) dut (
      .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .out_ack(out_ack), .ir_load(ir_load), .pc_en(pc_en),
      .RegDst(RegDst), .jump(jump), .Branch(Branch), .MemtoReg(MemtoReg),
      .ALUSrc(ALUSrc), .Jal(Jal), .JR(JR), .ALU_ctr(ALU_ctr), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .alu_start(alu_start),
      .out_valid(out_valid), .halted(halted), .illegal(illegal)
   );

   multicycle_control_unit #(.MULDIV_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .out_ack(out_ack), .ir_load(ir_load1), .pc_en(pc_en1),
      .RegDst(RegDst1), .jump(jump1), .Branch(Branch1), .MemtoReg(MemtoReg1),
      .ALUSrc(ALUSrc1), .Jal(Jal1), .JR(JR1), .ALU_ctr(ALU_ctr1), .reg_write(reg_write1),
      .mem_read(mem_read1), .mem_write(mem_write1), .alu_start(alu_start1),
      .out_valid(out_valid1), .halted(halted1), .illegal(illegal1)
   );

   typedef struct {
      string       name;
      logic [31:0] ins;
      int          dwait;
      int          ack_wait;
      int          cycles;
      logic        chk_alu;
      logic        chk_sel;
      logic [3:0]  alu;
      logic [6:0]  sel;
      int          rw, mr, mw, ill, start, ov;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] r_ins(input logic [5:0] fn);
      return {6'b000000, 20'h12345, fn};
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op);
      return {op, 26'h1234567};
   endfunction

   function automatic vec_t mk(input string name, input logic [31:0] ins, input int dwait,
                               input int ack_wait, input int cycles, input logic chk_alu,
                               input logic chk_sel, input logic [3:0] alu, input logic [6:0] sel,
                               input int rw, input int mr, input int mw, input int ill,
                               input int start, input int ov);
      vec_t v;
      v.name = name; v.ins = ins; v.dwait = dwait; v.ack_wait = ack_wait; v.cycles = cycles;
      v.chk_alu = chk_alu; v.chk_sel = chk_sel; v.alu = alu; v.sel = sel;
      v.rw = rw; v.mr = mr; v.mw = mw; v.ill = ill; v.start = start; v.ov = ov;
      return v;
   endfunction

   function automatic logic [6:0] sel_now();
      return {RegDst, jump, Branch, MemtoReg, ALUSrc, Jal, JR};
   endfunction

   function automatic logic [19:0] all_out();
      return {ir_load, pc_en, RegDst, jump, Branch, MemtoReg, ALUSrc, Jal, JR, ALU_ctr,
              reg_write, mem_read, mem_write, alu_start, out_valid, halted, illegal};
   endfunction

   function automatic logic [19:0] all_out1();
      return {ir_load1, pc_en1, RegDst1, jump1, Branch1, MemtoReg1, ALUSrc1, Jal1, JR1, ALU_ctr1,
              reg_write1, mem_read1, mem_write1, alu_start1, out_valid1, halted1, illegal1};
   endfunction

   // Leaves the bench 1 time unit after a rising edge with the DUTs in FETCH.
   task automatic do_reset();
      reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; out_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Runs one instruction from FETCH to retire; handshakes go high after the requested wait.
   task automatic run_vec(input vec_t v);
      vec_t       e;
      int         mseen = 0, oseen = 0, ret_cyc = 0, irl = 0, irl_cyc = 0, clash = 0;
      int         rw = 0, rw_cyc = 0, mr = 0, mw = 0, ill = 0, start = 0, ov = 0;
      logic [3:0] alu_dec = '0, alu_ret = '0;
      logic [6:0] sel_dec = '0, sel_ret = '0;
      bit         done = 0;
      sb.push_back(v);
      instr      = v.ins;
      imem_ready = 1'b1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done) break;
         dmem_ready = (mseen >= v.dwait);
         out_ack    = (oseen >= v.ack_wait);
         @(negedge clk);
         if (ir_load) begin
            irl++;
            if (irl_cyc == 0) irl_cyc = cyc;
         end
         if (ir_load && (reg_write || mem_read || mem_write || pc_en)) clash++;
         if (reg_write) begin rw++; rw_cyc = cyc; end
         mr    += int'(mem_read);
         mw    += int'(mem_write);
         ill   += int'(illegal);
         start += int'(alu_start);
         ov    += int'(out_valid);
         if (mem_read || mem_write) mseen++;
         if (out_valid) oseen++;
         if (cyc == 2) begin sel_dec = sel_now(); alu_dec = ALU_ctr; end
         if (pc_en) begin
            done = 1; ret_cyc = cyc; sel_ret = sel_now(); alu_ret = ALU_ctr;
         end
         @(posedge clk);
         #1;
      end
      e = sb.pop_front();
      check({e.name, " retired"}, int'(done), 1);
      if (!done) begin
         do_reset();
      end else begin
         check({e.name, " cycles"}, ret_cyc, e.cycles);
         check({e.name, " ir_load count"}, irl, 1);
         check({e.name, " ir_load cycle"}, irl_cyc, 1);
         check({e.name, " strobe with ir_load"}, clash, 0);
         check({e.name, " reg_write count"}, rw, e.rw);
         check({e.name, " reg_write cycle"}, rw_cyc, (e.rw > 0) ? e.cycles : 0);
         check({e.name, " mem_read cycles"}, mr, e.mr);
         check({e.name, " mem_write cycles"}, mw, e.mw);
         check({e.name, " illegal pulses"}, ill, e.ill);
         check({e.name, " alu_start pulses"}, start, e.start);
         check({e.name, " out_valid cycles"}, ov, e.ov);
         if (e.chk_alu) begin
            check({e.name, " ALU_ctr decode"}, int'(alu_dec), int'(e.alu));
            check({e.name, " ALU_ctr retire"}, int'(alu_ret), int'(e.alu));
         end
         if (e.chk_sel) begin
            check({e.name, " selects decode"}, int'(sel_dec), int'(e.sel));
            check({e.name, " selects retire"}, int'(sel_ret), int'(e.sel));
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int stray, halt_cnt, seen_mw, st_cyc, rw_cyc, st_cnt, st_cyc1, rw_cyc1, pc_cyc1, st_cnt1, pc_seen;
      bit ret0, ret1;

      reset = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; out_ack = 1'b0;

      // name, instr, dwait, ack_wait, cycles, chk_alu, chk_sel, alu, {RegDst,jump,Branch,MemtoReg,ALUSrc,Jal,JR}, rw, mr, mw, ill, start, ov
      vecs.push_back(mk("ADD",  r_ins(6'b100000), 0, 0, 4, 1, 1, 4'b0010, 7'b1000000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("SUB",  r_ins(6'b100010), 0, 0, 4, 1, 1, 4'b0110, 7'b1000000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("AND",  r_ins(6'b100100), 0, 0, 4, 1, 1, 4'b0000, 7'b1000000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("OR",   r_ins(6'b100101), 0, 0, 4, 1, 1, 4'b0001, 7'b1000000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("SLT",  r_ins(6'b101010), 0, 0, 4, 1, 1, 4'b0101, 7'b1000000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("COMP", r_ins(6'b111111), 0, 0, 4, 1, 1, 4'b0011, 7'b1000000, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("MULT", r_ins(6'b011000), 0, 0, 7, 1, 1, 4'b1000, 7'b1000000, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk("DIV",  r_ins(6'b011010), 0, 0, 7, 1, 1, 4'b1001, 7'b1000000, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk("ADDI", i_ins(6'b001000), 0, 0, 4, 1, 1, 4'b0010, 7'b0000100, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("SUBI", i_ins(6'b101010), 0, 0, 4, 1, 1, 4'b0110, 7'b0000100, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("LW",   i_ins(6'b100011), 0, 0, 5, 1, 1, 4'b0010, 7'b0001100, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk("LW wait2", i_ins(6'b100011), 2, 0, 7, 1, 1, 4'b0010, 7'b0001100, 1, 3, 0, 0, 0, 0));
      vecs.push_back(mk("SW",   i_ins(6'b101011), 0, 0, 4, 1, 1, 4'b0010, 7'b0000100, 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk("SW wait3", i_ins(6'b101011), 3, 0, 7, 1, 1, 4'b0010, 7'b0000100, 0, 0, 4, 0, 0, 0));
      vecs.push_back(mk("BEQ",  i_ins(6'b000100), 0, 0, 3, 1, 1, 4'b1010, 7'b0010000, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("BNE",  i_ins(6'b000101), 0, 0, 3, 1, 1, 4'b0011, 7'b0010000, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("BGT",  i_ins(6'b000111), 0, 0, 3, 1, 1, 4'b0100, 7'b0010000, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("BLT",  i_ins(6'b000001), 0, 0, 3, 1, 1, 4'b0101, 7'b0010000, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("J",    i_ins(6'b000010), 0, 0, 3, 1, 1, 4'b0000, 7'b0100000, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("JAL",  i_ins(6'b000011), 0, 0, 4, 1, 1, 4'b0000, 7'b0100010, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk("JR",   i_ins(6'b001111), 0, 0, 3, 1, 1, 4'b0000, 7'b0000001, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("OUT",  i_ins(6'b101110), 0, 0, 3, 1, 1, 4'b0000, 7'b0000000, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk("OUT ack5", i_ins(6'b101110), 0, 4, 7, 1, 1, 4'b0000, 7'b0000000, 0, 0, 0, 0, 0, 5));
      vecs.push_back(mk("bad funct",  r_ins(6'b000111), 0, 0, 3, 1, 0, 4'b1111, 7'b0000000, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk("bad opcode", i_ins(6'b110000), 0, 0, 3, 0, 0, 4'b0000, 7'b0000000, 0, 0, 0, 1, 0, 0));

      do_reset();
      @(negedge clk);
      check("reset outputs", int'(all_out()), 0);
      check("reset outputs lat1", int'(all_out1()), 0);
      @(posedge clk);
      #1;

      // Handshakes outside their own state must be ignored.
      out_ack = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b0;
      stray = 0;
      repeat (3) begin
         @(negedge clk);
         stray += int'(pc_en | out_valid | ir_load | mem_read | mem_write | reg_write);
      end
      @(posedge clk);
      #1;
      check("stray handshakes in FETCH", stray, 0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // MULT through both latencies side by side.
      do_reset();
      instr = r_ins(6'b011000); imem_ready = 1'b1; dmem_ready = 1'b1; out_ack = 1'b0;
      st_cyc = 0; rw_cyc = 0; st_cnt = 0; st_cyc1 = 0; rw_cyc1 = 0; pc_cyc1 = 0; st_cnt1 = 0;
      ret0 = 0; ret1 = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (ret0 && ret1) break;
         @(negedge clk);
         if (!ret0) begin
            if (alu_start) begin st_cnt++; st_cyc = cyc; end
            if (reg_write) rw_cyc = cyc;
            if (pc_en) ret0 = 1;
         end
         if (!ret1) begin
            if (alu_start1) begin st_cnt1++; st_cyc1 = cyc; end
            if (reg_write1) rw_cyc1 = cyc;
            if (pc_en1) begin ret1 = 1; pc_cyc1 = cyc; end
         end
         @(posedge clk);
         #1;
      end
      check("MULT lat4 alu_start pulses", st_cnt, 1);
      check("MULT lat4 alu_start cycle", st_cyc, 3);
      check("MULT lat4 WB cycle", rw_cyc, 7);
      check("MULT lat1 alu_start pulses", st_cnt1, 1);
      check("MULT lat1 alu_start cycle", st_cyc1, 3);
      check("MULT lat1 WB cycle", rw_cyc1, 4);
      check("MULT lat1 retire cycle", pc_cyc1, 4);

      // HALT is sticky: ten cycles of imem_ready change nothing.
      do_reset();
      instr = i_ins(6'b111111); imem_ready = 1'b1; dmem_ready = 1'b1; out_ack = 1'b1;
      stray = 0; halt_cnt = 0; pc_seen = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc <= 2) pc_seen += int'(pc_en);
         else begin
            halt_cnt += int'(halted);
            stray += int'(ir_load | pc_en | reg_write | mem_read | mem_write | alu_start | out_valid | illegal);
         end
         @(posedge clk);
         #1;
      end
      check("HALT no retire before halting", pc_seen, 0);
      check("HALT halted cycles", halt_cnt, 10);
      check("HALT strobes while halted", stray, 0);
      do_reset();
      @(negedge clk);
      check("outputs after reset from HALT", int'(all_out()), 0);
      @(posedge clk);
      #1;

      // Reset lands during MEM of a stalled SW, together with dmem_ready.
      instr = i_ins(6'b101011); imem_ready = 1'b1; dmem_ready = 1'b0; out_ack = 1'b0;
      seen_mw = 0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         if (seen_mw != 0) break;
         @(negedge clk);
         seen_mw = int'(mem_write);
         @(posedge clk);
         #1;
      end
      check("SW reached MEM", seen_mw, 1);
      reset = 1'b1; dmem_ready = 1'b1; imem_ready = 1'b0;
      @(negedge clk);
      check("pc_en with reset and dmem_ready", int'(pc_en), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mem_write after reset", int'(mem_write), 0);
      check("pc_en after reset", int'(pc_en), 0);
      check("outputs after reset in MEM", int'(all_out()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
